// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON packet front end: info-byte fields,
// error-flag indices and FSM state encodings.
package simon_pkg;

    localparam int unsigned INFO_MODE_LSB = 0;
    localparam int unsigned INFO_MODE_MSB = 3;
    localparam int unsigned INFO_DIR      = 4;
    localparam int unsigned INFO_KEY      = 5;
    localparam int unsigned INFO_TWO      = 7;

    localparam int unsigned ERR_COUNT = 0;
    localparam int unsigned ERR_MODE  = 1;
    localparam int unsigned ERR_DIR   = 2;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_CAPTURE = 3'd1;
    localparam logic [ST_W-1:0] ST_CHECK   = 3'd2;
    localparam logic [ST_W-1:0] ST_KEYWR   = 3'd3;
    localparam logic [ST_W-1:0] ST_PUSH0   = 3'd4;
    localparam logic [ST_W-1:0] ST_PUSH1   = 3'd5;

endpackage

// File: rtl/simon_blk_fifo.sv
// Block FIFO with first-word-fall-through head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module simon_blk_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_cnt != '0);
    assign w_do_push = i_push && ((r_cnt != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (R) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_cnt <= r_cnt - (AW+1)'(1);
            end
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/simon_pkt_in.sv
// SIMON packet input stage: captures packets, validates count/mode/direction,
// routes key packets to KEY and data blocks into a FIFO.
// Optional drop counter output enabled by SIMON_PKT_IN_ERRCNT_EN.
module simon_pkt_in
    import simon_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned M     = 4,
    parameter logic [3:0]  MODE  = 4'd0,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             newPkt,
    input  logic [4*N+15:0]  in,
    output logic             loadPkt,
    output logic             donePkt,
    output logic             newKey,
    input  logic             loadKey,
    output logic [M*N-1:0]   KEY,
    output logic             newData,
    input  logic             loadData,
    output logic [2*N-1:0]   blockIN,
    output logic [7:0]       infoIN,
    output logic [7:0]       countIN,
`ifdef SIMON_PKT_IN_ERRCNT_EN
    output logic [7:0]       errCount,
`endif
    output logic [2:0]       err
);

    localparam int unsigned PKT_W = 4*N + 16;
    localparam int unsigned ENT_W = 2*N + 16;

    logic [ST_W-1:0]  r_state;
    logic             r_pending;
    logic             r_newpkt_d;
    logic [PKT_W-1:0] r_pkt;
    logic [7:0]       r_exp;
    logic             r_loadpkt;
    logic             r_done;
    logic             r_newkey;
    logic [M*N-1:0]   r_key;
    logic [2:0]       r_err;

    logic [ST_W-1:0]  w_nxt_state;
    logic             w_nxt_pending;
    logic [7:0]       w_info;
    logic [7:0]       w_count;
    logic [N-1:0]     w_w0, w_w1, w_w2, w_w3;
    logic [2:0]       w_fail_bits;
    logic             w_chk_pass;
    logic             w_chk_fail;
    logic             w_key_wr;
    logic             w_push;
    logic             w_push_ok;
    logic [ENT_W-1:0] w_push_data;
    logic [ENT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    assign w_info  = r_pkt[4*N+8 +: 8];
    assign w_count = r_pkt[4*N +: 8];
    assign w_w0    = r_pkt[0 +: N];
    assign w_w1    = r_pkt[N +: N];
    assign w_w2    = r_pkt[2*N +: N];
    assign w_w3    = r_pkt[3*N +: N];

    assign w_pop     = !w_empty && loadData;
    assign w_push_ok = !w_full || w_pop;

    // Next-state and datapath strobes
    always_comb begin
        w_nxt_state  = r_state;
        w_chk_pass   = 1'b0;
        w_chk_fail   = 1'b0;
        w_key_wr     = 1'b0;
        w_push       = 1'b0;
        w_push_data  = {w_info, w_count, w_w2, w_w3};
        w_fail_bits  = 3'b000;
        w_fail_bits[ERR_COUNT] = (w_count != r_exp);
        w_fail_bits[ERR_MODE]  = (w_info[INFO_MODE_MSB:INFO_MODE_LSB] != MODE);
        w_fail_bits[ERR_DIR]   = w_info[INFO_DIR];

        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_nxt_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_nxt_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_fail_bits != 3'b000) begin
                    w_chk_fail  = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_chk_pass  = 1'b1;
                    w_nxt_state = w_info[INFO_KEY] ? ST_KEYWR : ST_PUSH0;
                end
            end
            ST_KEYWR: begin
                if (!r_newkey) begin
                    w_key_wr    = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_PUSH0: begin
                w_push = w_push_ok;
                if (w_info[INFO_TWO]) begin
                    w_push_data = {w_info, w_count, w_w0, w_w1};
                end
                if (w_push_ok) begin
                    w_nxt_state = w_info[INFO_TWO] ? ST_PUSH1 : ST_IDLE;
                end
            end
            ST_PUSH1: begin
                w_push = w_push_ok;
                if (w_push_ok) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // A fresh edge during capture stays pending for the next packet
        w_nxt_pending = (newPkt && !r_newpkt_d) || (r_pending && (r_state != ST_CAPTURE));
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= ST_IDLE;
            r_pending  <= 1'b0;
            r_newpkt_d <= 1'b0;
            r_pkt      <= '0;
            r_exp      <= 8'd0;
            r_loadpkt  <= 1'b0;
            r_done     <= 1'b1;
            r_newkey   <= 1'b0;
            r_key      <= '0;
            r_err      <= 3'b000;
        end else begin
            r_state    <= w_nxt_state;
            r_pending  <= w_nxt_pending;
            r_newpkt_d <= newPkt;
            r_loadpkt  <= (w_nxt_state == ST_CAPTURE);
            r_done     <= (w_nxt_state == ST_IDLE) && !w_nxt_pending;
            if (r_state == ST_CAPTURE) begin
                r_pkt <= in;
            end
            if (w_chk_pass) begin
                r_exp <= r_exp + 8'd1;
            end
            if (w_chk_fail) begin
                r_err <= r_err | w_fail_bits;
            end
            if (w_key_wr) begin
                r_key    <= r_pkt[M*N-1:0];
                r_newkey <= 1'b1;
            end else if (loadKey && r_newkey) begin
                r_newkey <= 1'b0;
            end
        end
    end

`ifdef SIMON_PKT_IN_ERRCNT_EN
    logic [7:0] r_errcnt;

    // Saturating count of dropped packets
    always_ff @(posedge clk) begin
        if (R) begin
            r_errcnt <= 8'd0;
        end else if (w_chk_fail && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end

    assign errCount = r_errcnt;
`endif

    simon_blk_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .R       (R),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign loadPkt = r_loadpkt;
    assign donePkt = r_done;
    assign newKey  = r_newkey;
    assign KEY     = r_key;
    assign err     = r_err;
    assign newData = !w_empty;
    assign {infoIN, countIN, blockIN} = w_head;

endmodule

// File: tb/tb_simon_pkt_in.sv
// Randomized self-checking bench for simon_pkt_in against a packet-level model.
module tb_simon_pkt_in;

    localparam int unsigned N     = 16;
    localparam int unsigned M     = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  MODE  = 4'd0;
    localparam int unsigned EW    = 2*N + 16;

    logic             clk = 1'b0;
    logic             R;
    logic             newPkt;
    logic [4*N+15:0]  pkt_in;
    logic             loadPkt;
    logic             donePkt;
    logic             newKey;
    logic             loadKey;
    logic [M*N-1:0]   KEY;
    logic             newData;
    logic             loadData;
    logic [2*N-1:0]   blockIN;
    logic [7:0]       infoIN;
    logic [7:0]       countIN;
    logic [2:0]       err;
`ifdef SIMON_PKT_IN_ERRCNT_EN
    logic [7:0]       errCount;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]     m_exp;
    logic [2:0]     m_err;
    logic [M*N-1:0] m_key;
    logic [EW-1:0]  m_q [$];

    simon_pkt_in #(.N(N), .M(M), .MODE(MODE), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .R        (R),
        .newPkt   (newPkt),
        .in       (pkt_in),
        .loadPkt  (loadPkt),
        .donePkt  (donePkt),
        .newKey   (newKey),
        .loadKey  (loadKey),
        .KEY      (KEY),
        .newData  (newData),
        .loadData (loadData),
        .blockIN  (blockIN),
        .infoIN   (infoIN),
        .countIN  (countIN),
`ifdef SIMON_PKT_IN_ERRCNT_EN
        .errCount (errCount),
`endif
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [N-1:0] rw();
        return N'($urandom);
    endfunction

    task automatic model_clear();
        m_exp = 8'd0;
        m_err = 3'b000;
        m_key = '0;
        m_q.delete();
    endtask

    // Packet-level reference: validate, then update counter, key or block queue
    task automatic model_pkt(input logic [7:0] info, input logic [7:0] cnt,
                             input logic [N-1:0] w0, input logic [N-1:0] w1,
                             input logic [N-1:0] w2, input logic [N-1:0] w3);
        logic [2:0] bad;
        bad[0] = (cnt != m_exp);
        bad[1] = (info[3:0] != MODE);
        bad[2] = info[4];
        if (bad != 3'b000) begin
            m_err = m_err | bad;
        end else begin
            m_exp = m_exp + 8'd1;
            if (info[5]) begin
                m_key = {w3, w2, w1, w0};
            end else begin
                if (info[7]) m_q.push_back({info, cnt, w0, w1});
                m_q.push_back({info, cnt, w2, w3});
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] info, input logic [7:0] cnt,
                            input logic [N-1:0] w0, input logic [N-1:0] w1,
                            input logic [N-1:0] w2, input logic [N-1:0] w3,
                            input bit wait_done);
        int n;
        @(negedge clk);
        pkt_in = {info, cnt, w3, w2, w1, w0};
        newPkt = 1'b1;
        n = 0;
        while (loadPkt !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (loadPkt !== 1'b1) begin
            n_fail++;
            $display("FAIL loadPkt_seen: got %b expected 1", loadPkt);
        end
        @(negedge clk);
        newPkt = 1'b0;
        n_cmp++;
        if (loadPkt !== 1'b0) begin
            n_fail++;
            $display("FAIL loadPkt_one_cycle: got %b expected 0", loadPkt);
        end
        model_pkt(info, cnt, w0, w1, w2, w3);
        if (wait_done) begin
            n = 0;
            while (donePkt !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (donePkt !== 1'b1) begin
                n_fail++;
                $display("FAIL donePkt_return: got %b expected 1", donePkt);
            end
        end
    endtask

    task automatic test_reset();
        R = 1'b1; newPkt = 1'b0; pkt_in = '0; loadKey = 1'b0; loadData = 1'b0;
        repeat (3) @(negedge clk);
        model_clear();
        n_cmp++;
        if ({loadPkt, newKey, newData, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {loadPkt, newKey, newData, err});
        end
        n_cmp++;
        if (donePkt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 1", donePkt);
        end
        n_cmp++;
        if ({KEY, blockIN, infoIN, countIN} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected 0", KEY, blockIN, infoIN, countIN);
        end
        R = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_key();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) send_pkt(8'h20, m_exp, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
            else        send_pkt(8'h20, m_exp, rw(), rw(), rw(), rw(), 1'b1);
            n_cmp++;
            if (newKey !== 1'b1 || KEY !== m_key) begin
                n_fail++;
                $display("FAIL key_load: got nk=%b %h expected nk=1 %h", newKey, KEY, m_key);
            end
            loadKey = 1'b1;
            @(negedge clk);
            loadKey = 1'b0;
            n_cmp++;
            if (newKey !== 1'b0 || newData !== 1'b0) begin
                n_fail++;
                $display("FAIL key_consume: got nk=%b nd=%b expected 0 0", newKey, newData);
            end
        end
    endtask

    task automatic test_data();
        logic [EW-1:0] exp_e;
        logic [7:0]    info;
        for (int p = 0; p < 8; p++) begin
            info = (p == 0) ? 8'h80 : (p == 1) ? 8'h00 : {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 6'b0};
            send_pkt(info, m_exp, rw(), rw(), rw(), rw(), 1'b1);
            while (m_q.size() > 0) begin
                exp_e = m_q.pop_front();
                n_cmp++;
                if (newData !== 1'b1 || {infoIN, countIN, blockIN} !== exp_e) begin
                    n_fail++;
                    $display("FAIL data_head: got nd=%b %h expected %h", newData, {infoIN, countIN, blockIN}, exp_e);
                end
                loadData = 1'b1;
                @(negedge clk);
                loadData = 1'b0;
            end
            n_cmp++;
            if (newData !== 1'b0) begin
                n_fail++;
                $display("FAIL data_empty: got %b expected 0", newData);
            end
        end
    endtask

    task automatic test_errors();
        logic [EW-1:0] exp_e;
        send_pkt(8'h00, m_exp + 8'd3, rw(), rw(), rw(), rw(), 1'b1);
        n_cmp++;
        if (err !== m_err || err !== 3'b001 || newData !== 1'b0) begin
            n_fail++;
            $display("FAIL err_count: got err=%b nd=%b expected err=001 nd=0", err, newData);
        end
        send_pkt(8'h13, m_exp, rw(), rw(), rw(), rw(), 1'b1);
        n_cmp++;
        if (err !== m_err || newData !== 1'b0) begin
            n_fail++;
            $display("FAIL err_mode_dir: got err=%b nd=%b expected err=%b nd=0", err, newData, m_err);
        end
        // Counter must not have advanced on the drops
        send_pkt(8'h00, m_exp, rw(), rw(), rw(), rw(), 1'b1);
        exp_e = m_q.pop_front();
        n_cmp++;
        if (err !== m_err || newData !== 1'b1 || {infoIN, countIN, blockIN} !== exp_e) begin
            n_fail++;
            $display("FAIL err_recover: got err=%b %h expected err=%b %h", err, {infoIN, countIN, blockIN}, m_err, exp_e);
        end
        loadData = 1'b1;
        @(negedge clk);
        loadData = 1'b0;
    endtask

    task automatic test_stall();
        logic [EW-1:0] exp_e;
        int n;
        send_pkt(8'h80, m_exp, rw(), rw(), rw(), rw(), 1'b1);
        send_pkt(8'h80, m_exp, rw(), rw(), rw(), rw(), 1'b1);
        send_pkt(8'h80, m_exp, rw(), rw(), rw(), rw(), 1'b0);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (donePkt !== 1'b0 || newData !== 1'b1 || {infoIN, countIN, blockIN} !== m_q[0]) begin
            n_fail++;
            $display("FAIL stall_hold: got done=%b %h expected done=0 %h", donePkt, {infoIN, countIN, blockIN}, m_q[0]);
        end
        while (m_q.size() > 0) begin
            exp_e = m_q.pop_front();
            n_cmp++;
            if (newData !== 1'b1 || {infoIN, countIN, blockIN} !== exp_e) begin
                n_fail++;
                $display("FAIL stall_drain: got nd=%b %h expected %h", newData, {infoIN, countIN, blockIN}, exp_e);
            end
            loadData = 1'b1;
            @(negedge clk);
            loadData = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (donePkt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (donePkt !== 1'b1 || newData !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: got done=%b nd=%b expected 1 0", donePkt, newData);
        end
    endtask

    task automatic test_reset_mid();
        send_pkt(8'h80, m_exp, rw(), rw(), rw(), rw(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (newData !== 1'b1 || donePkt !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: got nd=%b done=%b expected 1 0", newData, donePkt);
        end
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        model_clear();
        n_cmp++;
        if (newData !== 1'b0 || donePkt !== 1'b1 || err !== 3'b000 || KEY !== '0 || newKey !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got nd=%b done=%b err=%b expected 0 1 000", newData, donePkt, err);
        end
        send_pkt(8'h20, 8'd0, rw(), rw(), rw(), rw(), 1'b1);
        n_cmp++;
        if (err !== 3'b000 || newKey !== 1'b1 || KEY !== m_key) begin
            n_fail++;
            $display("FAIL mid_counter: got err=%b nk=%b expected err=000 nk=1", err, newKey);
        end
        loadKey = 1'b1;
        @(negedge clk);
        loadKey = 1'b0;
    endtask

    task automatic test_wrap();
        logic [EW-1:0] exp_e;
        for (int p = 0; p < 256; p++) begin
            send_pkt({$urandom_range(0, 1) == 1, 7'b0}, m_exp, rw(), rw(), rw(), rw(), 1'b1);
            while (m_q.size() > 0) begin
                exp_e = m_q.pop_front();
                n_cmp++;
                if (newData !== 1'b1 || {infoIN, countIN, blockIN} !== exp_e) begin
                    n_fail++;
                    $display("FAIL wrap_head: got nd=%b %h expected %h", newData, {infoIN, countIN, blockIN}, exp_e);
                end
                loadData = 1'b1;
                @(negedge clk);
                loadData = 1'b0;
            end
        end
        n_cmp++;
        if (err !== 3'b000 || m_exp !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_err: got err=%b expected 000", err);
        end
    endtask

`ifdef SIMON_PKT_IN_ERRCNT_EN
    task automatic test_errcnt();
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        model_clear();
        n_cmp++;
        if (errCount !== 8'd0) begin
            n_fail++;
            $display("FAIL errcnt_reset: got %0d expected 0", errCount);
        end
        for (int p = 0; p < 300; p++) begin
            send_pkt(8'h00, m_exp + 8'd1, rw(), rw(), rw(), rw(), 1'b1);
        end
        n_cmp++;
        if (errCount !== 8'd255 || err !== m_err) begin
            n_fail++;
            $display("FAIL errcnt_sat: got %0d err=%b expected 255 err=%b", errCount, err, m_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_key();
        test_data();
        test_errors();
        test_stall();
        test_reset_mid();
        test_wrap();
`ifdef SIMON_PKT_IN_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
